// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker state encoding, PRBS7 feedback taps and
// the next-bit predictor for x^7 + x^6 + 1.
package prbs_pkg;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } prbs_chk_state_t;

    // History bit positions feeding the predictor (h[0] is the newest bit).
    localparam int PRBS7_TAP_A = 6;
    localparam int PRBS7_TAP_B = 5;

    // Next expected bit for a sequence obeying s[n+7] = s[n] ^ s[n+1].
    function automatic logic prbs7_pred(input logic [6:0] h);
        return h[PRBS7_TAP_A] ^ h[PRBS7_TAP_B];
    endfunction

endpackage

// File: rtl/prbs7_checker_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Count up on inc, stick at all-ones, return to zero on clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= {W{1'b0}};
        end else if (clr) begin
            r_q <= {W{1'b0}};
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_q <= r_q;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/prbs7_checker.sv
// Serial PRBS7 checker. Self-synchronises on the received stream, then
// free-runs a local reference, flags and counts bit errors, and drops lock
// when too many errors land inside one observation window.
module prbs7_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT   = 16,
    parameter int WIN_LEN    = 128,
    parameter int UNLOCK_ERR = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             clr,
    output logic             lock,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(WIN_LEN);
    localparam int WERR_W  = $clog2(UNLOCK_ERR + 1);

    prbs_chk_state_t     r_state;
    logic [6:0]          r_h;
    logic [2:0]          r_fill;
    logic [MATCH_W-1:0]  r_match;
    logic [WIN_W-1:0]    r_win_cnt;
    logic [WERR_W-1:0]   r_win_err;
    logic                r_lock;
    logic                r_err;

    logic                w_pred;
    logic                w_mis;
    logic                w_locked_sample;
    logic                w_fill_done;
    logic                w_match_ok;
    logic [MATCH_W-1:0]  w_match_next;
    logic [WERR_W-1:0]   w_err_sum;
    logic                w_unlock;
    logic                w_win_last;

    assign w_pred          = prbs7_pred(r_h);
    assign w_mis           = din ^ w_pred;
    assign w_locked_sample = en & (r_state == LOCKED);
    assign w_fill_done     = (r_fill == 3'd7);
    // An all-zero history predicts zero forever, so it must never count as a match.
    assign w_match_ok      = (din == w_pred) && (r_h != 7'd0);
    assign w_match_next    = r_match + MATCH_W'(1);
    // The current bit's error is included so the unlocking error itself is counted.
    assign w_err_sum       = r_win_err + WERR_W'(w_mis);
    assign w_unlock        = w_mis && (w_err_sum >= WERR_W'(UNLOCK_ERR));
    assign w_win_last      = (r_win_cnt == WIN_W'(WIN_LEN - 1));

    // Acquisition/tracking FSM with history, window bookkeeping and registered flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= SEARCH;
            r_h       <= 7'd0;
            r_fill    <= 3'd0;
            r_match   <= {MATCH_W{1'b0}};
            r_win_cnt <= {WIN_W{1'b0}};
            r_win_err <= {WERR_W{1'b0}};
            r_lock    <= 1'b0;
            r_err     <= 1'b0;
        end else if (en) begin
            case (r_state)
                SEARCH: begin
                    r_h   <= {r_h[5:0], din};
                    r_err <= 1'b0;
                    if (!w_fill_done) begin
                        r_fill  <= r_fill + 3'd1;
                        r_match <= {MATCH_W{1'b0}};
                    end else if (w_match_ok) begin
                        if (w_match_next == MATCH_W'(LOCK_CNT)) begin
                            r_state   <= LOCKED;
                            r_lock    <= 1'b1;
                            r_match   <= {MATCH_W{1'b0}};
                            r_win_cnt <= {WIN_W{1'b0}};
                            r_win_err <= {WERR_W{1'b0}};
                        end else begin
                            r_match <= w_match_next;
                        end
                    end else begin
                        r_match <= {MATCH_W{1'b0}};
                    end
                end
                LOCKED: begin
                    // Feed back the prediction so one flipped input bit yields one error.
                    r_h   <= {r_h[5:0], w_pred};
                    r_err <= w_mis;
                    if (w_unlock) begin
                        r_state   <= SEARCH;
                        r_lock    <= 1'b0;
                        r_fill    <= 3'd0;
                        r_match   <= {MATCH_W{1'b0}};
                        r_win_cnt <= {WIN_W{1'b0}};
                        r_win_err <= {WERR_W{1'b0}};
                    end else if (w_win_last) begin
                        r_win_cnt <= {WIN_W{1'b0}};
                        r_win_err <= {WERR_W{1'b0}};
                    end else begin
                        r_win_cnt <= r_win_cnt + WIN_W'(1);
                        r_win_err <= w_err_sum;
                    end
                end
                default: begin
                    r_state <= SEARCH;
                    r_lock  <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end else begin
            r_err <= 1'b0;
        end
    end

    sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_locked_sample & w_mis),
        .clr (clr),
        .q   (err_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_locked_sample),
        .clr (clr),
        .q   (bit_cnt)
    );

    assign lock = r_lock;
    assign err  = r_err;

endmodule

// File: tb/tb_prbs7_checker.sv
// Directed bench for prbs7_checker: a 32-bit-counter instance and a 4-bit-counter
// instance share one stimulus stream; a scoreboard queue carries the expected
// outputs of every driven sample to the point where the DUT produces them.
module tb_prbs7_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        din;
    logic        clr;

    logic        lock_a;
    logic        err_a;
    logic [31:0] errc_a;
    logic [31:0] bitc_a;
    logic        lock_b;
    logic        err_b;
    logic [3:0]  errc_b;
    logic [3:0]  bitc_b;

    prbs7_checker u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .din     (din),
        .clr     (clr),
        .lock    (lock_a),
        .err     (err_a),
        .err_cnt (errc_a),
        .bit_cnt (bitc_a)
    );

    prbs7_checker #(.CNT_W(4)) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .din     (din),
        .clr     (clr),
        .lock    (lock_b),
        .err     (err_b),
        .err_cnt (errc_b),
        .bit_cnt (bitc_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic err;
        logic lock;
        int   errs;
        int   bits;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference generator and expected-behaviour model state.
    logic [6:0]  g;
    logic        m_lock;
    int          m_run;
    int          m_win;
    int          m_werr;
    int          m_errs;
    int          m_bits;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_lock_a"}, 32'(lock_a), 32'd0);
        chk({tag, "_err_a"},  32'(err_a),  32'd0);
        chk({tag, "_errc_a"}, errc_a,      32'd0);
        chk({tag, "_bitc_a"}, bitc_a,      32'd0);
        chk({tag, "_lock_b"}, 32'(lock_b), 32'd0);
        chk({tag, "_errc_b"}, 32'(errc_b), 32'd0);
        chk({tag, "_bitc_b"}, 32'(bitc_b), 32'd0);
    endtask

    task automatic model_reset();
        m_lock = 1'b0;
        m_run  = 0;
        m_win  = 0;
        m_werr = 0;
        m_errs = 0;
        m_bits = 0;
        g      = 7'h7F;
        sb_q.delete();
    endtask

    // Reset asserted between clock edges; outputs must clear before any posedge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        din = 1'b0;
        clr = 1'b0;
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock of stimulus: e=enable, flip=invert the generator bit,
    // zero=drive constant 0 instead of the generator, c=clear counters.
    task automatic step(input logic e, input logic flip, input logic zero, input logic c);
        exp_t x;
        exp_t y;
        logic b;
        b = 1'b0;
        @(negedge clk);
        en  = e;
        clr = c;
        if (e) begin
            if (!zero) begin
                b = g[6];
                g = {g[5:0], g[6] ^ g[5]};
            end
            din = b ^ flip;
        end else begin
            din = 1'($urandom_range(0, 1));
        end
        x.err = e & m_lock & flip;
        if (e) begin
            if (m_lock) begin
                m_bits++;
                if (flip) m_errs++;
                if (flip && (m_werr + 1 >= 8)) begin
                    m_lock = 1'b0;
                    m_run  = 0;
                    m_win  = 0;
                    m_werr = 0;
                end else if (m_win == 127) begin
                    m_win  = 0;
                    m_werr = 0;
                end else begin
                    m_win++;
                    if (flip) m_werr++;
                end
            end else if (zero || flip) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == 23) m_lock = 1'b1;
            end
        end
        if (c) begin
            m_errs = 0;
            m_bits = 0;
        end
        x.lock = m_lock;
        x.errs = m_errs;
        x.bits = m_bits;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        y = sb_q.pop_front();
        chk("err_a",  32'(err_a),  32'(y.err));
        chk("lock_a", 32'(lock_a), 32'(y.lock));
        chk("errc_a", errc_a,      32'(y.errs));
        chk("bitc_a", bitc_a,      32'(y.bits));
        chk("err_b",  32'(err_b),  32'(y.err));
        chk("lock_b", 32'(lock_b), 32'(y.lock));
        chk("errc_b", 32'(errc_b), 32'(sat15(y.errs)));
        chk("bitc_b", 32'(bitc_b), 32'(sat15(y.bits)));
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        din = 1'b0;
        clr = 1'b0;
        model_reset();

        // T1: clean stream from seed 7'h7F, lock on the 23rd sample, then 1000 clean bits.
        do_reset();
        repeat (22) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_lock_before_23", 32'(lock_a), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_lock_at_23", 32'(lock_a), 32'd1);
        repeat (1000) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_bitc", bitc_a, 32'd1000);
        chk("t1_errc", errc_a, 32'd0);

        // T2: one inverted bit gives exactly one err pulse, lock holds.
        repeat (50) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t2_err_pulse", 32'(err_a), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_err_gone", 32'(err_a), 32'd0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_errc", errc_a, 32'd1);
        chk("t2_lock", 32'(lock_a), 32'd1);

        // T3: move into a fresh window, clear counters, then 8 errors in one window.
        repeat (100) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t3_clr", errc_a, 32'd0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            chk("t3_lock_held", 32'(lock_a), 32'd1);
            repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3_unlock_8th", 32'(lock_a), 32'd0);
        repeat (22) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_not_yet_relocked", 32'(lock_a), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_relock", 32'(lock_a), 32'd1);
        chk("t3_errc", errc_a, 32'd8);

        // T4: all-zero stream must never lock.
        do_reset();
        repeat (500) step(1'b1, 1'b0, 1'b1, 1'b0);
        chk_all_zero("t4");

        // T5: 20 spread errors; 4-bit counter saturates, then clr beats a simultaneous error.
        do_reset();
        repeat (23) step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            repeat (19) step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0, 1'b0);
        end
        chk("t5_errc_b_sat", 32'(errc_b), 32'd15);
        chk("t5_errc_a", errc_a, 32'd20);
        chk("t5_lock", 32'(lock_b), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("t5_clr_errc_b", 32'(errc_b), 32'd0);
        chk("t5_clr_errc_a", errc_a, 32'd0);

        // T6: random enable, lock and single-error behaviour, then reset mid-lock.
        do_reset();
        for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        while (!m_lock) step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        chk("t6_errc", errc_a, 32'd1);
        chk("t6_lock", 32'(lock_a), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6_err_before_rst", 32'(err_a), 32'd1);
        rst = 1'b1;
        #2;
        chk_all_zero("t6_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
